breath_led_sched: RTL

Four-channel breathing-LED scheduler that decides which LEDs breathe, in what order, and when. It runs a shared breathing timebase: a fine tick, a PWM period and a ramp counter, with an up ramp followed by a down ramp. It gates the resulting PWM onto `led[3:0]` according to a mode and channel mask latched at start. It sits between board-level control (buttons or a register block) and the LED pins.

---
 rtl/breath_led_sched_if.sv | 20 ++
 rtl/breath_led_sched.sv | 204 ++++++++++++++++++++
 2 files changed

// File: rtl/breath_led_sched_if.sv
// Control/status bundle between the board-level controller and the breathing-LED scheduler.
interface breath_led_sched_if;
  logic       start;
  logic       stop;
  logic [1:0] mode;
  logic [3:0] mask;
  logic [3:0] led;
  logic       busy;
  logic       cycle_done;

  modport master (
    output start, stop, mode, mask,
    input  led, busy, cycle_done
  );

  modport slave (
    input  start, stop, mode, mask,
    output led, busy, cycle_done
  );
endinterface

// File: rtl/breath_led_sched.sv
// Four-channel breathing-LED scheduler: shared up/down PWM ramp timebase gated onto
// led[3:0] by a per-breath active set chosen from the mode and mask latched at start.
//
// state   | meaning
// --------+--------------------------------------------------------------
// ST_IDLE | counters held at 0, led dark, waiting for an accepted start
// ST_UP   | brightening ramp, pwm = cnt_ms < cnt_s
// ST_DOWN | dimming ramp, pwm = cnt_ms >= cnt_s; breath ends on its last tick
module breath_led_sched #(
  parameter int DELAY_2US = 100,
  parameter int DELAY_2MS = 1000,
  parameter int DELAY_2S  = 1000
) (
  input  logic                sclk,
  input  logic                s_rst,
  breath_led_sched_if.slave   bus
);

  localparam int W_US = (DELAY_2US > 1) ? $clog2(DELAY_2US) : 1;
  localparam int W_MS = (DELAY_2MS > 1) ? $clog2(DELAY_2MS) : 1;
  localparam int W_S  = (DELAY_2S  > 1) ? $clog2(DELAY_2S)  : 1;

  localparam logic [W_US-1:0] TC_US  = W_US'(DELAY_2US - 1);
  localparam logic [W_MS-1:0] TC_MS  = W_MS'(DELAY_2MS - 1);
  localparam logic [W_S-1:0]  TC_S   = W_S'(DELAY_2S - 1);
  localparam logic [W_US-1:0] ONE_US = W_US'(1);
  localparam logic [W_MS-1:0] ONE_MS = W_MS'(1);
  localparam logic [W_S-1:0]  ONE_S  = W_S'(1);

  localparam logic [3:0] PAIR_02 = 4'b0101;
  localparam logic [3:0] PAIR_13 = 4'b1010;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_UP   = 2'd1,
    ST_DOWN = 2'd2
  } state_t;

  state_t          state_q, state_d;
  logic [W_US-1:0] cnt_us_q, cnt_us_d;
  logic [W_MS-1:0] cnt_ms_q, cnt_ms_d;
  logic [W_S-1:0]  cnt_s_q, cnt_s_d;
  logic [1:0]      mode_q, mode_d;
  logic [3:0]      mask_q, mask_d;
  logic [3:0]      active_q, active_d;
  logic            stop_pend_q, stop_pend_d;
  logic [3:0]      led_q, led_d;
  logic            cycle_done_q, cycle_done_d;

  logic tick_us, tick_ms, ramp_end, pwm, stop_eff, accept;

  // Search from the channel after (or before, when dn) the current one, wrapping;
  // a single-bit mask lands back on the same channel on the fourth probe.
  function automatic logic [3:0] chase_next(input logic [3:0] m, input logic [3:0] cur,
                                            input logic dn);
    logic [1:0] idx;
    logic [1:0] probe;
    logic       found;
    logic [3:0] res;
    idx   = 2'd0;
    for (int i = 0; i < 4; i++) begin
      if (cur[i]) idx = 2'(i);
    end
    res   = cur;
    found = 1'b0;
    for (int k = 1; k <= 4; k++) begin
      probe = dn ? (idx - 2'(k)) : (idx + 2'(k));
      if (!found && m[probe]) begin
        res   = 4'b0001 << probe;
        found = 1'b1;
      end
    end
    return res;
  endfunction

  function automatic logic [3:0] first_active(input logic [1:0] md, input logic [3:0] m);
    logic [3:0] res;
    case (md)
      2'b00:   res = m;
      2'b01:   res = chase_next(m, 4'b1000, 1'b0);
      2'b10:   res = chase_next(m, 4'b0001, 1'b1);
      default: res = ((m & PAIR_02) != 4'b0) ? (m & PAIR_02) : (m & PAIR_13);
    endcase
    return res;
  endfunction

  function automatic logic [3:0] next_active(input logic [1:0] md, input logic [3:0] m,
                                             input logic [3:0] cur);
    logic [3:0] res;
    case (md)
      2'b00:   res = m;
      2'b01:   res = chase_next(m, cur, 1'b0);
      2'b10:   res = chase_next(m, cur, 1'b1);
      default: begin
        if ((cur & PAIR_02) != 4'b0)
          res = ((m & PAIR_13) != 4'b0) ? (m & PAIR_13) : (m & PAIR_02);
        else
          res = ((m & PAIR_02) != 4'b0) ? (m & PAIR_02) : (m & PAIR_13);
      end
    endcase
    return res;
  endfunction

  assign tick_us  = (cnt_us_q == TC_US);
  assign tick_ms  = tick_us && (cnt_ms_q == TC_MS);
  assign ramp_end = tick_ms && (cnt_s_q == TC_S);
  assign stop_eff = stop_pend_q | bus.stop;
  assign accept   = bus.start && !bus.stop && (bus.mask != 4'b0);

  always_comb begin
    pwm = 1'b0;
    case (state_q)
      ST_UP:   pwm = (32'(cnt_ms_q) <  32'(cnt_s_q));
      ST_DOWN: pwm = (32'(cnt_ms_q) >= 32'(cnt_s_q));
      default: pwm = 1'b0;
    endcase
  end

  always_comb begin
    state_d      = state_q;
    cnt_us_d     = cnt_us_q;
    cnt_ms_d     = cnt_ms_q;
    cnt_s_d      = cnt_s_q;
    mode_d       = mode_q;
    mask_d       = mask_q;
    active_d     = active_q;
    stop_pend_d  = stop_pend_q;
    led_d        = 4'b0;
    cycle_done_d = 1'b0;

    case (state_q)
      ST_IDLE: begin
        cnt_us_d    = '0;
        cnt_ms_d    = '0;
        cnt_s_d     = '0;
        stop_pend_d = 1'b0;
        if (accept) begin
          state_d  = ST_UP;
          mode_d   = bus.mode;
          mask_d   = bus.mask;
          active_d = first_active(bus.mode, bus.mask);
        end
      end

      ST_UP, ST_DOWN: begin
        cnt_us_d    = tick_us ? '0 : (cnt_us_q + ONE_US);
        if (tick_us) cnt_ms_d = tick_ms ? '0 : (cnt_ms_q + ONE_MS);
        if (tick_ms) cnt_s_d  = ramp_end ? '0 : (cnt_s_q + ONE_S);
        stop_pend_d = stop_eff;
        led_d       = {4{pwm}} & active_q;

        if (ramp_end) begin
          if (state_q == ST_UP) begin
            state_d = ST_DOWN;
          end else begin
            cycle_done_d = 1'b1;
            if (stop_eff) begin
              // led must already be dark in the cycle busy falls
              state_d     = ST_IDLE;
              stop_pend_d = 1'b0;
              led_d       = 4'b0;
            end else begin
              state_d  = ST_UP;
              active_d = next_active(mode_q, mask_q, active_q);
            end
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state_q      <= ST_IDLE;
      cnt_us_q     <= '0;
      cnt_ms_q     <= '0;
      cnt_s_q      <= '0;
      mode_q       <= 2'b0;
      mask_q       <= 4'b0;
      active_q     <= 4'b0;
      stop_pend_q  <= 1'b0;
      led_q        <= 4'b0;
      cycle_done_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_us_q     <= cnt_us_d;
      cnt_ms_q     <= cnt_ms_d;
      cnt_s_q      <= cnt_s_d;
      mode_q       <= mode_d;
      mask_q       <= mask_d;
      active_q     <= active_d;
      stop_pend_q  <= stop_pend_d;
      led_q        <= led_d;
      cycle_done_q <= cycle_done_d;
    end
  end

  assign bus.led        = led_q;
  assign bus.busy       = (state_q != ST_IDLE);
  assign bus.cycle_done = cycle_done_q;

endmodule
